// File: rtl/usb_tx_serializer_if.sv
// Packet-request and line-side bundle for usb_tx_serializer.
// Defining USB_TX_ABORT_EN adds the abort request and the aborted status pulse.
interface usb_tx_serializer_if;
   logic        start;
   logic [3:0]  pid;
   logic [63:0] payload;
   logic [1:0]  port;
   logic        busy;
   logic        done;
   logic        pid_err;
`ifdef USB_TX_ABORT_EN
   logic        abort;
   logic        aborted;

   modport master (output start, pid, payload, abort, input port, busy, done, pid_err, aborted);
   modport slave  (input start, pid, payload, abort, output port, busy, done, pid_err, aborted);
`else
   modport master (output start, pid, payload, input port, busy, done, pid_err);
   modport slave  (input start, pid, payload, output port, busy, done, pid_err);
`endif
endinterface

// File: rtl/usb_tx_serializer.sv
// USB bit-serial transmitter: SYNC, PID, payload, CRC5/CRC16 and EOP with bit stuffing and NRZI.
// Optional abort path is enabled by defining USB_TX_ABORT_EN.
module usb_tx_serializer #(
   parameter int SYNC_BITS   = 8,
   parameter int STUFF_LIMIT = 6
) (
   input  logic               clk,
   input  logic               rst,
   usb_tx_serializer_if.slave bus
);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LIMIT);
   localparam logic [6:0] SYNC_LAST = 7'(SYNC_BITS - 1);
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

   function automatic logic pid_valid(input logic [3:0] p);
      case (p)
         PID_OUT, PID_IN, PID_DATA0, PID_ACK, PID_NAK: pid_valid = 1'b1;
         default: pid_valid = 1'b0;
      endcase
   endfunction

   function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
      logic fb;
      fb = d ^ c[4];
      crc5_step = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
   endfunction

   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
      logic fb;
      fb = d ^ c[15];
      crc16_step = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   // The state registers describe the next bit to emit (a cursor one bit ahead of the line).
   state_t        state_r, cur_state_s, next_field_s;
   logic [6:0]    idx_r, cur_idx_s, data_last_s;
   logic [OW-1:0] ones_r, cur_ones_s;
   logic [15:0]   crc_r;
   logic [3:0]    pid_r, crc_sel_s;
   logic [63:0]   payload_r;
   logic [1:0]    port_r, cur_level_s, toggle_s, line_s;
   logic          busy_r, done_r, pid_err_r, abort_flag_r;
   logic          accept_s, abort_s, stuff_s, bit_s, last_s, crc16_s, has_data_s;
`ifdef USB_TX_ABORT_EN
   logic          aborted_r;
`endif

   // Request acceptance and cursor selection; an accepted start emits SYNC bit 0 from level J at once.
   always_comb begin
      accept_s = bus.start & ~busy_r & pid_valid(bus.pid);
`ifdef USB_TX_ABORT_EN
      abort_s = bus.abort & ((state_r == S_SYNC) | (state_r == S_PID) | (state_r == S_DATA) | (state_r == S_CRC));
`else
      abort_s = 1'b0;
`endif
      if (accept_s) begin
         cur_state_s = S_SYNC;
         cur_idx_s   = 7'd0;
         cur_ones_s  = '0;
         cur_level_s = LINE_J;
      end else begin
         cur_state_s = state_r;
         cur_idx_s   = idx_r;
         cur_ones_s  = ones_r;
         cur_level_s = port_r;
      end
      toggle_s    = (cur_level_s == LINE_J) ? LINE_K : LINE_J;
      crc16_s     = (pid_r == PID_DATA0);
      has_data_s  = crc16_s | (pid_r == PID_OUT) | (pid_r == PID_IN);
      data_last_s = crc16_s ? 7'd63 : 7'd10;
      crc_sel_s   = crc16_s ? (4'd15 - cur_idx_s[3:0]) : (4'd4 - cur_idx_s[3:0]);
      stuff_s     = (cur_state_s != S_IDLE) && (cur_ones_s == STUFF_MAX);
   end

   // Field bit selection and NRZI line value for the bit under the cursor.
   always_comb begin
      bit_s        = 1'b0;
      last_s       = 1'b0;
      next_field_s = S_IDLE;
      case (cur_state_s)
         S_SYNC: begin
            bit_s        = (cur_idx_s == SYNC_LAST);
            last_s       = bit_s;
            next_field_s = S_PID;
         end
         S_PID: begin
            bit_s        = pid_r[cur_idx_s[1:0]] ^ cur_idx_s[2];
            last_s       = (cur_idx_s == 7'd7);
            next_field_s = has_data_s ? S_DATA : S_EOP;
         end
         S_DATA: begin
            bit_s        = payload_r[cur_idx_s[5:0]];
            last_s       = (cur_idx_s == data_last_s);
            next_field_s = S_CRC;
         end
         S_CRC: begin
            bit_s        = ~crc_r[crc_sel_s];
            last_s       = (cur_idx_s[3:0] == (crc16_s ? 4'd15 : 4'd4));
            next_field_s = S_EOP;
         end
         default: begin
            bit_s        = 1'b0;
            last_s       = 1'b0;
            next_field_s = S_IDLE;
         end
      endcase
      if (cur_state_s == S_IDLE) begin
         line_s = LINE_J;
      end else if (stuff_s || (cur_state_s != S_EOP && !bit_s)) begin
         line_s = toggle_s;
      end else if (cur_state_s != S_EOP) begin
         line_s = cur_level_s;
      end else if (cur_idx_s == 7'd2) begin
         line_s = LINE_J;
      end else begin
         line_s = LINE_SE0;
      end
   end

   // Transmit FSM: advances the cursor, stuffs, updates CRC and drives the registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         idx_r        <= 7'd0;
         ones_r       <= '0;
         crc_r        <= 16'hFFFF;
         pid_r        <= 4'b0000;
         payload_r    <= 64'd0;
         port_r       <= LINE_J;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pid_err_r    <= 1'b0;
         abort_flag_r <= 1'b0;
`ifdef USB_TX_ABORT_EN
         aborted_r    <= 1'b0;
`endif
      end else begin
         done_r    <= 1'b0;
         pid_err_r <= bus.start & ~busy_r & ~pid_valid(bus.pid);
         busy_r    <= accept_s | (state_r != S_IDLE);
         port_r    <= line_s;
`ifdef USB_TX_ABORT_EN
         aborted_r <= 1'b0;
`endif
         if (accept_s) begin
            pid_r        <= bus.pid;
            payload_r    <= bus.payload;
            crc_r        <= 16'hFFFF;
            abort_flag_r <= 1'b0;
         end
         if (abort_s) begin
            port_r       <= LINE_SE0;
            state_r      <= S_EOP;
            idx_r        <= 7'd1;
            ones_r       <= '0;
            abort_flag_r <= 1'b1;
         end else if (cur_state_s == S_IDLE) begin
            state_r <= S_IDLE;
            idx_r   <= 7'd0;
            ones_r  <= '0;
         end else if (stuff_s) begin
            state_r <= cur_state_s;
            idx_r   <= cur_idx_s;
            ones_r  <= '0;
         end else if (cur_state_s == S_EOP) begin
            ones_r <= '0;
            if (cur_idx_s == 7'd2) begin
               state_r <= S_IDLE;
               idx_r   <= 7'd0;
               done_r  <= ~abort_flag_r;
`ifdef USB_TX_ABORT_EN
               aborted_r <= abort_flag_r;
`endif
            end else begin
               state_r <= S_EOP;
               idx_r   <= cur_idx_s + 7'd1;
            end
         end else begin
            ones_r <= bit_s ? (cur_ones_s + OW'(1)) : '0;
            if (cur_state_s == S_DATA) begin
               crc_r <= crc16_s ? crc16_step(crc_r, bit_s) : {crc_r[15:5], crc5_step(crc_r[4:0], bit_s)};
            end
            state_r <= last_s ? next_field_s : cur_state_s;
            idx_r   <= last_s ? 7'd0 : (cur_idx_s + 7'd1);
         end
      end
   end

   assign bus.port    = port_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.pid_err = pid_err_r;
`ifdef USB_TX_ABORT_EN
   assign bus.aborted = aborted_r;
`endif
endmodule
